wb_sram_sp_bridge: RTL

//  Wishbone B3 slave front-end that feeds the single-port byte-select SRAM (sram_sp).

---
 rtl/wb_sram_sp_bridge.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_sram_sp_bridge.sv
// wb_sram_sp_bridge
//   Wishbone B3 slave front-end for the single-port byte-select SRAM.
//   Turns classic and incrementing-burst cycles into SRAM strobes and
//   prefetches burst reads so that every beat is acknowledged in one clock.
//   Accesses at or above MEM_SIZE complete with wb_err_o instead of wb_ack_o.
//
//   Handshake: a transfer is requested while wb_cyc_i & wb_stb_i are high.
//   The request is completed in the cycle wb_ack_o (or wb_err_o) is high.
//   The master must hold address, data, we, sel and cti stable until then.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_adr_i..wb_bte_i    Wishbone slave inputs (byte address, bits [1:0] ignored)
//   wb_dat_o, wb_ack_o    read data / transfer acknowledge
//   wb_err_o, wb_rty_o    error acknowledge (out of range) / retry (never used)
//   sram_ce/we/oe         SRAM strobes, oe = ce & ~we
//   sram_addr             word-aligned SRAM byte address
//   sram_din, sram_sel    write data and byte selects, straight from the bus
//   sram_dout             SRAM read data, valid the cycle after a read is issued
module wb_sram_sp_bridge #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] MEM_SIZE = AW'(32'h8000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              sram_ce,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_din,
  output logic [DW/8-1:0]   sram_sel,
  input  logic [DW-1:0]     sram_dout
);

  typedef enum logic [1:0] {IDLE, ACK, BURST, ERR} state_t;

  // state is left visible by hierarchical reference for debug and checkers
  state_t        state;
  logic [AW-1:0] burst_adr;   // next read to prefetch (reads) / current beat (writes)
  logic [AW-1:0] beat_adr;    // address the master must present on the current beat
  logic          burst_we;
  logic [1:0]    burst_bte;

  logic          req, oor, beat_ok, last_beat, is_inc, is_end;
  logic [AW-1:0] adr_w, beat_next;
  logic [1:0]    start_bte;
  logic          ack_c, err_c, ce_c, we_c;
  logic [AW-1:0] addr_c;

  // Next word address for a burst; wrap-N keeps the upper word bits and
  // increments only the low log2(N) bits.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-3:0] w, inc;
    w   = a[AW-1:2];
    inc = w + (AW-2)'(1);
    case (bte)
      2'b01:   w[1:0] = inc[1:0];
      2'b10:   w[2:0] = inc[2:0];
      2'b11:   w[3:0] = inc[3:0];
      default: w      = inc;
    endcase
    return {w, 2'b00};
  endfunction

  assign req       = wb_cyc_i & wb_stb_i;
  assign oor       = (wb_adr_i >= MEM_SIZE);
  assign adr_w     = {wb_adr_i[AW-1:2], 2'b00};
  assign is_inc    = (wb_cti_i == 3'b010);
  assign is_end    = (wb_cti_i == 3'b111);
  // Classic cycles prefetch linearly; the prefetch is simply never used.
  assign start_bte = is_inc ? wb_bte_i : 2'b00;
  assign beat_next = next_adr(beat_adr, burst_bte);
  assign beat_ok   = req && (wb_adr_i[AW-1:2] == beat_adr[AW-1:2]) && (wb_we_i == burst_we);
  assign last_beat = is_end || (beat_next >= MEM_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_adr <= '0;
      beat_adr  <= '0;
      burst_we  <= 1'b0;
      burst_bte <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (oor) begin
              state <= ERR;
            end else begin
              beat_adr  <= adr_w;
              burst_we  <= wb_we_i;
              burst_bte <= start_bte;
              burst_adr <= wb_we_i ? adr_w : next_adr(adr_w, start_bte);
              state     <= is_inc ? BURST : ACK;
            end
          end
        end
        ACK: state <= IDLE;
        ERR: state <= IDLE;
        BURST: begin
          if (beat_ok) begin
            beat_adr <= beat_next;
            if (burst_we)
              burst_adr <= beat_next;
            else if (!last_beat)
              burst_adr <= next_adr(burst_adr, burst_bte);
            state <= last_beat ? IDLE : BURST;
          end else begin
            // Broken beat: drop back and let IDLE treat any request as new.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ack_c  = 1'b0;
    err_c  = 1'b0;
    ce_c   = 1'b0;
    we_c   = 1'b0;
    addr_c = '0;
    case (state)
      IDLE: begin
        if (req && !oor && !wb_we_i) begin
          ce_c   = 1'b1;
          addr_c = adr_w;
        end
      end
      ACK: begin
        if (req) begin
          ack_c = 1'b1;
          if (burst_we) begin
            ce_c   = 1'b1;
            we_c   = 1'b1;
            addr_c = beat_adr;
          end
        end
      end
      BURST: begin
        if (beat_ok) begin
          ack_c = 1'b1;
          if (burst_we) begin
            ce_c   = 1'b1;
            we_c   = 1'b1;
            addr_c = beat_adr;
          end else if (!last_beat) begin
            ce_c   = 1'b1;
            addr_c = burst_adr;
          end
        end
      end
      ERR: err_c = req;
      default: ;
    endcase
  end

  // Outputs are forced low while reset is asserted so a master that keeps
  // driving a request cannot produce an SRAM access during reset.
  assign wb_ack_o  = ack_c & rst_n;
  assign wb_err_o  = err_c & rst_n;
  assign wb_rty_o  = 1'b0;
  assign sram_ce   = ce_c & rst_n;
  assign sram_we   = we_c & rst_n;
  assign sram_oe   = ce_c & ~we_c & rst_n;
  assign sram_addr = rst_n ? addr_c : '0;
  assign sram_din  = rst_n ? wb_dat_i : '0;
  assign sram_sel  = rst_n ? wb_sel_i : '0;
  assign wb_dat_o  = rst_n ? sram_dout : '0;

endmodule
